// File: rtl/clock_crossing_arbiter.sv
// Arbiter sharing one clock-crossing bridge slave port among requesters.
// Define CLOCK_CROSSING_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module clock_crossing_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int RSP_DEPTH = 8,
  parameter int ID_W      = 3
) (
  input  logic                    slave_clk,
  input  logic                    slave_reset_n,
  input  logic [NUM_REQ-1:0]      req_read,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [NUM_REQ*28-1:0]   req_address,
  input  logic [NUM_REQ*2-1:0]    req_burstcount,
  input  logic [NUM_REQ*4-1:0]    req_byteenable,
  input  logic [NUM_REQ*32-1:0]   req_writedata,
  output logic [NUM_REQ-1:0]      req_waitrequest,
  output logic [NUM_REQ-1:0]      req_readdatavalid,
  output logic [31:0]             req_readdata,
  output logic                    br_read,
  output logic                    br_write,
  output logic [27:0]             br_address,
  output logic [27:0]             br_nativeaddress,
  output logic [1:0]              br_burstcount,
  output logic [3:0]              br_byteenable,
  output logic [31:0]             br_writedata,
  input  logic                    br_waitrequest,
  input  logic                    br_readdatavalid,
  input  logic [31:0]             br_readdata,
  output logic                    rsp_err
);
  localparam int AW = $clog2(RSP_DEPTH);

  typedef enum logic {IDLE, WBURST} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] lock_q, lock_d;
  logic [1:0]      beats_q, beats_d;
`ifndef CLOCK_CROSSING_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0] last_q, last_d;
`endif

  logic [NUM_REQ-1:0] req_any, gnt_oh;
  logic [ID_W-1:0]    gnt_id;
  logic               found;
  logic               cmd_rd, cmd_wr;
  logic [1:0]         cmd_bc;
  logic               acc_rd, acc_wr;

  logic [ID_W-1:0] id_mem  [RSP_DEPTH];
  logic [1:0]      cnt_mem [RSP_DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            empty, full, push, pop, rsp_hit;
  logic [ID_W-1:0] head_id;
  logic [1:0]      head_cnt;

  assign req_any  = req_read | req_write;
  assign empty    = wr_ptr == rd_ptr;
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_id  = id_mem[rd_ptr[AW-1:0]];
  assign head_cnt = cnt_mem[rd_ptr[AW-1:0]];

  always_comb begin
    gnt_oh = '0;
    gnt_id = '0;
    found  = 1'b0;
    unique case (1'b1)
      state_q == WBURST: begin
        for (int i = 0; i < NUM_REQ; i++)
          if (i == int'(lock_q) && req_write[i]) begin
            gnt_oh[i] = 1'b1;
            gnt_id    = lock_q;
          end
      end
      state_q == IDLE: begin
`ifdef CLOCK_CROSSING_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NUM_REQ; i++)
          if (!found && req_any[i]) begin
            found     = 1'b1;
            gnt_oh[i] = 1'b1;
            gnt_id    = ID_W'(i);
          end
`else
        for (int k = 1; k <= NUM_REQ; k++)
          for (int i = 0; i < NUM_REQ; i++)
            if (!found && req_any[i] &&
                i == (int'(last_q) + k) % NUM_REQ) begin
              found     = 1'b1;
              gnt_oh[i] = 1'b1;
              gnt_id    = ID_W'(i);
            end
`endif
      end
    endcase
  end

  always_comb begin
    cmd_rd        = 1'b0;
    cmd_wr        = 1'b0;
    cmd_bc        = 2'd1;
    br_address    = '0;
    br_byteenable = '0;
    br_writedata  = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt_oh[i]) begin
        cmd_wr        = req_write[i];
        cmd_rd        = req_read[i] & ~req_write[i];
        br_address    = req_address[28*i +: 28];
        cmd_bc        = req_burstcount[2*i +: 2];
        br_byteenable = req_byteenable[4*i +: 4];
        br_writedata  = req_writedata[32*i +: 32];
      end
    if (cmd_bc == 2'd0)
      cmd_bc = 2'd1;
  end

  // A read is held off while no tracking slot is free
  assign br_read          = cmd_rd & ~full;
  assign br_write         = cmd_wr;
  assign br_nativeaddress = br_address;
  assign br_burstcount    = cmd_bc;
  assign acc_rd           = br_read & ~br_waitrequest;
  assign acc_wr           = br_write & ~br_waitrequest;

  assign req_waitrequest =
    ~gnt_oh | {NUM_REQ{br_waitrequest | ~(br_read | br_write)}};

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    beats_d = beats_q;
`ifndef CLOCK_CROSSING_ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    unique case (1'b1)
      state_q == IDLE: begin
`ifndef CLOCK_CROSSING_ARB_FIXED_PRIO_EN
        if (acc_wr || acc_rd)
          last_d = gnt_id;
`endif
        if (acc_wr && cmd_bc != 2'd1) begin
          state_d = WBURST;
          lock_d  = gnt_id;
          beats_d = cmd_bc - 2'd1;
        end
      end
      state_q == WBURST: begin
        if (acc_wr) begin
          beats_d = beats_q - 2'd1;
          if (beats_q == 2'd1)
            state_d = IDLE;
        end
      end
    endcase
  end

  assign push    = acc_rd;
  assign rsp_hit = br_readdatavalid & ~empty;
  assign pop     = rsp_hit & (head_cnt == 2'd1);

  always_ff @(posedge slave_clk or negedge slave_reset_n) begin
    if (!slave_reset_n) begin
      state_q <= IDLE;
      lock_q  <= '0;
      beats_q <= '0;
`ifndef CLOCK_CROSSING_ARB_FIXED_PRIO_EN
      last_q  <= ID_W'(NUM_REQ - 1);
`endif
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rsp_err <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      beats_q <= beats_d;
`ifndef CLOCK_CROSSING_ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (br_readdatavalid && empty)
        rsp_err <= 1'b1;
    end
  end

  // Push slot never aliases the head: pushes are blocked when full
  always_ff @(posedge slave_clk) begin
    if (push) begin
      id_mem[wr_ptr[AW-1:0]]  <= gnt_id;
      cnt_mem[wr_ptr[AW-1:0]] <= cmd_bc;
    end
    if (rsp_hit)
      cnt_mem[rd_ptr[AW-1:0]] <= head_cnt - 2'd1;
  end

  always_comb begin
    req_readdatavalid = '0;
    for (int i = 0; i < NUM_REQ; i++)
      req_readdatavalid[i] = rsp_hit && head_id == ID_W'(i);
  end

  assign req_readdata = br_readdata;

endmodule

// File: doc/clock_crossing_arbiter.md
# clock_crossing_arbiter

Slave-clock-domain arbiter that shares one Avalon-MM clock-crossing bridge slave port among `NUM_REQ` requesters. It grants one requester at a time, locks the grant for the whole of a write burst, and records each issued read so that returning read data is routed back to the requester that asked for it. It sits directly in front of the bridge's slave (s1) port, entirely in `slave_clk`.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..8.
- `RSP_DEPTH`, 8: outstanding-read tracking FIFO depth, power of two.
- `ID_W`, 3: requester-index width; must satisfy 2^`ID_W` >= `NUM_REQ`.

Ports:
- `slave_clk`  in  1  clock for all logic.
- `slave_reset_n`  in  1  asynchronous, active-low reset.
- `req_read`  in  NUM_REQ  per-requester read strobe.
- `req_write`  in  NUM_REQ  per-requester write strobe.
- `req_address`  in  NUM_REQ*28  word addresses, requester i at [28i+27:28i].
- `req_burstcount`  in  NUM_REQ*2  burst lengths (1..3).
- `req_byteenable`  in  NUM_REQ*4  byte enables.
- `req_writedata`  in  NUM_REQ*32  write data.
- `req_waitrequest`  out  NUM_REQ  per-requester stall.
- `req_readdatavalid`  out  NUM_REQ  per-requester read-data strobe.
- `req_readdata`  out  32  read data, broadcast to all requesters.
- `br_read`, `br_write`  out  1  bridge command strobes.
- `br_address`, `br_nativeaddress`  out  28  both driven with the granted word address.
- `br_burstcount`  out  2  granted burst length.
- `br_byteenable`  out  4  granted byte enables.
- `br_writedata`  out  32  granted write data.
- `br_waitrequest`  in  1  bridge stall (downstream FIFO full).
- `br_readdatavalid`  in  1  bridge read-data strobe.
- `br_readdata`  in  32  bridge read data.
- `rsp_err`  out  1  sticky flag: read data arrived with no outstanding entry.

## Operation
- Arbitration state machine:
  - IDLE: round-robin search among requesters with `read|write` asserted, starting at `last_grant+1` and wrapping. The winner's command is driven combinationally to `br_*`.
  - In IDLE, a winning read is blocked while the tracking FIFO is full.
  - A write beat accepted (`!br_waitrequest`) with burstcount > 1 moves to WBURST, loads `beats_left` = burstcount-1, and locks the grant.
  - WBURST: only the locked requester is served. Each accepted write beat decrements `beats_left`; returns to IDLE when it reaches 0. Read strobes from the locked requester are ignored in WBURST.
- `last_grant` updates when a read is accepted or when a write burst's first beat is accepted.
- burstcount 0 is treated as 1.
- `req_waitrequest[i]` = !granted(i) | `br_waitrequest` | (read & FIFO full). Non-requesting lanes read 1.
- Read tracking:
  - Each accepted read pushes {id, burstcount} into the tracking FIFO.
  - The head entry's beat counter decrements on each `br_readdatavalid`; the entry pops when the counter reaches 0.
  - A push and a pop in the same cycle are both performed.
- Read routing: `req_readdatavalid[i]` = `br_readdatavalid` & head.id==i & !empty. `br_readdata` is passed straight through to `req_readdata`.
- Error case: `br_readdatavalid` with the FIFO empty is dropped and sets `rsp_err`. `rsp_err` clears only on reset.

## Timing
- Command path from requester to bridge is combinational (0 cycles); there are no registered command outputs.
- Response routing is combinational (0 cycles) from `br_readdatavalid`.
- Reset values: state=IDLE, `last_grant`=NUM_REQ-1 (so requester 0 wins first), `beats_left`=0, FIFO empty, `rsp_err`=0. All `br_*` strobes read 0 and `req_readdatavalid`=0.
- Asynchronous reset mid-burst or with reads outstanding abandons all tracking. Read data returning after reset sets `rsp_err`.
- Back-to-back: a new grant may be issued in the cycle after WBURST exits, or in the same cycle a single-beat command is accepted with a different winner the next cycle.
- `br_waitrequest` holds all `br_*` outputs stable. The state machine does not advance on stalled cycles.

## Configuration
- `CLOCK_CROSSING_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins, and `last_grant` is unused.
  - Undefined (default): round-robin as described.
  - Write-burst locking and read tracking are identical in both modes.

## Test plan
- Reset, then requesters 0 and 1 both assert single reads continuously -> grants alternate 0,1,0,1. Four reads issued in four unstalled cycles.
- Requester 1 issues a write burst of 3 while requester 0 requests a read -> `br_write` for 3 beats from requester 1 with no interleave. Requester 0 is granted on the following cycle.
- Requester 0 reads burst 2, then requester 1 reads burst 1, then 3 data beats return -> `req_readdatavalid` pattern 0,0,1.
- Nine single reads issued with no data returned (RSP_DEPTH=8) -> the ninth is stalled with `req_waitrequest`=1. One returned beat releases it.
- `br_waitrequest` held high for 5 cycles mid write burst -> `br_*` outputs are stable, `beats_left` is unchanged, and the burst completes after release.
- `br_readdatavalid` pulsed after reset with nothing outstanding -> `rsp_err`=1 and all `req_readdatavalid`=0. With the macro defined and both requesting, requester 0 always wins.
